// File: rtl/demux_2_stream.sv
// Registered 1-to-2 valid/ready stream demultiplexer with a one-entry holding register per channel.
// Optional per-channel delivered-beat counters are built when DEMUX_2_CNT_EN is defined.
module demux_2_stream #(
    parameter int N     = 64,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N-1:0]     i_in,
    input  logic             i_s,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [N-1:0]     o_out0,
    output logic             o_valid0,
    input  logic             i_ready0,
    output logic [N-1:0]     o_out1,
    output logic             o_valid1,
    input  logic             i_ready1
`ifdef DEMUX_2_CNT_EN
    ,
    output logic [CNT_W-1:0] o_cnt0,
    output logic [CNT_W-1:0] o_cnt1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t      state_q [2];
    chan_state_t      state_d [2];
    logic [N-1:0]     data_q  [2];
    logic [N-1:0]     data_d  [2];

    logic [1:0]       sel;
    logic [1:0]       cons_ready;
    logic [1:0]       accept;
    logic [1:0]       drain;

    assign sel        = {i_s, ~i_s};
    assign cons_ready = {i_ready1, i_ready0};

    // A channel can take a beat when empty or when its current beat leaves this same edge.
    assign o_ready = i_s ? (state_q[1] == EMPTY || i_ready1)
                         : (state_q[0] == EMPTY || i_ready0);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            accept[k]  = i_valid & o_ready & sel[k];
            drain[k]   = (state_q[k] == FULL) & cons_ready[k];
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            if (accept[k]) begin
                state_d[k] = FULL;
                data_d[k]  = i_in;
            end else if (drain[k]) begin
                state_d[k] = EMPTY;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the payload registers are
    // reset as well because the outputs must read zero during reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
        end
    end

    assign o_valid0 = (state_q[0] == FULL);
    assign o_valid1 = (state_q[1] == FULL);
    assign o_out0   = data_q[0];
    assign o_out1   = data_q[1];

`ifdef DEMUX_2_CNT_EN
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    // Counters wrap naturally at 2^CNT_W.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            cnt_d[k] = drain[k] ? cnt_q[k] + 1'b1 : cnt_q[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign o_cnt0 = cnt_q[0];
    assign o_cnt1 = cnt_q[1];
`endif

endmodule

// File: tb/tb_demux_2_stream.sv
// Self-checking bench for demux_2_stream: vector table plus a queue scoreboard per channel.
// Counter checks are compiled in when DEMUX_2_CNT_EN is defined.
module tb_demux_2_stream;

    localparam int N     = 64;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     in_data;
    logic             s;
    logic             valid;
    logic             ready;
    logic [N-1:0]     out0;
    logic             valid0;
    logic             ready0;
    logic [N-1:0]     out1;
    logic             valid1;
    logic             ready1;
`ifdef DEMUX_2_CNT_EN
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
`endif

    demux_2_stream #(.N(N), .CNT_W(CNT_W)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_in     (in_data),
        .i_s      (s),
        .i_valid  (valid),
        .o_ready  (ready),
        .o_out0   (out0),
        .o_valid0 (valid0),
        .i_ready0 (ready0),
        .o_out1   (out1),
        .o_valid1 (valid1),
        .i_ready1 (ready1)
`ifdef DEMUX_2_CNT_EN
        ,
        .o_cnt0   (cnt0),
        .o_cnt1   (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: one queue per channel holds the beat the channel should be presenting.
    logic [N-1:0] q0[$];
    logic [N-1:0] q1[$];
    bit           sb_en = 1'b0;

    always @(negedge clk) begin
        if (sb_en && rst_n) begin
            logic exp_v0, exp_v1, exp_rdy;
            exp_v0  = (q0.size() != 0);
            exp_v1  = (q1.size() != 0);
            exp_rdy = s ? (!exp_v1 || ready1) : (!exp_v0 || ready0);
            check("sb_valid0", valid0, exp_v0);
            check("sb_valid1", valid1, exp_v1);
            check("sb_ready", ready, exp_rdy);
            if (exp_v0) check("sb_out0", out0, q0[0]);
            if (exp_v1) check("sb_out1", out1, q1[0]);
            if (exp_v0 && ready0) void'(q0.pop_front());
            if (exp_v1 && ready1) void'(q1.pop_front());
            if (valid && exp_rdy) begin
                if (s) q1.push_back(in_data);
                else   q0.push_back(in_data);
            end
        end
    end

    typedef struct {
        logic         v;
        logic         s;
        logic [N-1:0] d;
        logic         r0;
        logic         r1;
        logic         exp_ready;
        logic         exp_v0;
        logic         exp_v1;
    } vec_t;

    vec_t vecs [10];

    task automatic drive(input logic v, input logic sel, input logic [N-1:0] d,
                         input logic r0, input logic r1);
        valid   = v;
        s       = sel;
        in_data = d;
        ready0  = r0;
        ready1  = r1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset a few ns after the edge, away from any clock edge, then releases it.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("rst_valid0", valid0, 1'b0);
        check("rst_valid1", valid1, 1'b0);
        check("rst_out0", out0, '0);
        check("rst_out1", out1, '0);
`ifdef DEMUX_2_CNT_EN
        check("rst_cnt0", cnt0, '0);
        check("rst_cnt1", cnt1, '0);
`endif
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Route and backpressure-isolation vectors; expected values observed before each edge.
        //            v     s     d      r0    r1    rdy   v0    v1
        vecs[0] = '{1'b1, 1'b0, 64'hA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 64'hB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 64'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 64'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 64'h3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 64'h4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{1'b0, 1'b1, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        #3;
        check("init_valid0", valid0, 1'b0);
        check("init_valid1", valid1, 1'b0);
        check("init_out0", out0, '0);
        check("init_out1", out1, '0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        sb_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].r0, vecs[i].r1);
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), ready, vecs[i].exp_ready);
            check($sformatf("vec%0d_valid0", i), valid0, vecs[i].exp_v0);
            check($sformatf("vec%0d_valid1", i), valid1, vecs[i].exp_v1);
            if (i == 4 || i == 5) check($sformatf("vec%0d_hold_out0", i), out0, 64'h1);
            if (i == 6) check("vec6_out1", out1, 64'h3);
            next_cycle();
        end

        // Back-to-back: 8 beats to ch0 with the consumer always ready.
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, 1'b0, 64'h100 + 64'(i), 1'b1, 1'b1);
            @(negedge clk);
            if (i >= 1 && i <= 8) begin
                check($sformatf("b2b%0d_valid0", i), valid0, 1'b1);
                check($sformatf("b2b%0d_out0", i), out0, 64'h100 + 64'(i - 1));
            end
            next_cycle();
        end

        // Randomised traffic, checked by the scoreboard alone.
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            next_cycle();
        end

        // Reset mid-transfer: ch1 holds 0xFF that must never be delivered.
        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        repeat (2) next_cycle();
        drive(1'b1, 1'b1, 64'hFF, 1'b0, 1'b0);
        next_cycle();
        drive(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("mid_valid1_full", valid1, 1'b1);
        check("mid_out1_full", out1, 64'hFF);
        do_reset();
        drive(1'b0, 1'b1, '0, 1'b1, 1'b1);
        @(negedge clk);
        check("post_rst_valid1", valid1, 1'b0);
        check("post_rst_valid0", valid0, 1'b0);
        next_cycle();

`ifdef DEMUX_2_CNT_EN
        // 17 ch0 deliveries wrap a 4-bit counter to 1; ch1 stays at 0.
        for (int i = 0; i < 19; i++) begin
            drive(i < 17, 1'b0, 64'h200 + 64'(i), 1'b1, 1'b1);
            next_cycle();
        end
        check("cnt0_wrap", cnt0, 4'd1);
        check("cnt1_idle", cnt1, 4'd0);
`endif

        drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
        repeat (3) next_cycle();
        sb_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
